// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg
// Shared RV32I definitions used by the register file, ALU and decoder.
// Contents:
//   XLEN        - integer register / datapath width
//   REG_ADDR_W  - register index width
//   NUM_REGS    - number of architectural integer registers
//   reg_addr_t  - register index type
//   xlen_t      - datapath word type
//   REG_ZERO    - index of the hardwired-zero register x0
// ---------------------------------------------------------------------------
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage : rv32_pkg

// File: rtl/reg_file_if.sv
// ---------------------------------------------------------------------------
// reg_file_if
// Bundles the read and write ports of the integer register file.
// Signals:
//   rs1_addr_i / rs2_addr_i  - read port indices (ALU a / b operand)
//   rs1_data_o / rs2_data_o  - read port data
//   rd_we_i                  - write enable
//   rd_addr_i                - write index
//   rd_data_i                - write data from the write-back mux
//   write_ack_o              - one-cycle pulse after an effective write
// Modports:
//   master - core side (drives indices and write data)
//   slave  - register file side
// ---------------------------------------------------------------------------
interface reg_file_if #(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int ADDR_W = rv32_pkg::REG_ADDR_W
);

  logic [ADDR_W-1:0] rs1_addr_i;
  logic [ADDR_W-1:0] rs2_addr_i;
  logic [XLEN-1:0]   rs1_data_o;
  logic [XLEN-1:0]   rs2_data_o;
  logic              rd_we_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [XLEN-1:0]   rd_data_i;
  logic              write_ack_o;

  modport master (
    output rs1_addr_i, rs2_addr_i, rd_we_i, rd_addr_i, rd_data_i,
    input  rs1_data_o, rs2_data_o, write_ack_o
  );

  modport slave (
    input  rs1_addr_i, rs2_addr_i, rd_we_i, rd_addr_i, rd_data_i,
    output rs1_data_o, rs2_data_o, write_ack_o
  );

endinterface : reg_file_if

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// RV32I integer register file: two combinational read ports and one
// synchronous write port. x0 always reads as zero and is never written.
// Optional same-cycle write-to-read bypass (BYPASS_EN=1) for pipelined use.
// Ports:
//   clk_i  - core clock, state updates on the rising edge
//   rst_i  - synchronous active-high reset, clears all entries and the ack
//   bus    - reg_file_if slave modport (read ports, write port, write ack)
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int XLEN      = rv32_pkg::XLEN,
  parameter int NUM_REGS  = rv32_pkg::NUM_REGS,
  parameter int ADDR_W    = rv32_pkg::REG_ADDR_W,
  parameter bit BYPASS_EN = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  reg_file_if.slave      bus
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            write_ack;
  logic            write_hit;
  logic [XLEN-1:0] rs1_stored;
  logic [XLEN-1:0] rs2_stored;

  // A write only takes effect for a non-zero index; x0 writes are silent no-ops.
  assign write_hit = bus.rd_we_i && (bus.rd_addr_i != rv32_pkg::REG_ZERO);

  // Reset wins over a coincident write so mid-program reset always lands
  // in a fully cleared state in a single edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      write_ack <= 1'b0;
    end else begin
      if (write_hit) begin
        regs[bus.rd_addr_i] <= bus.rd_data_i;
      end
      write_ack <= write_hit;
    end
  end

  // Shared read logic for both ports. The bypass is gated off during reset
  // so a dropped write never leaks onto a read port.
  function automatic logic [XLEN-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [XLEN-1:0]   stored,
    input logic              rst,
    input logic              hit,
    input logic [ADDR_W-1:0] waddr,
    input logic [XLEN-1:0]   wdata
  );
    logic [XLEN-1:0] data;
    data = stored;
    if (addr == rv32_pkg::REG_ZERO) begin
      data = '0;
    end else if (BYPASS_EN && !rst && hit && (waddr == addr)) begin
      data = wdata;
    end
    return data;
  endfunction

  always_comb begin
    rs1_stored = regs[bus.rs1_addr_i];
    rs2_stored = regs[bus.rs2_addr_i];
  end

  assign bus.rs1_data_o  = read_port(bus.rs1_addr_i, rs1_stored, rst_i, write_hit,
                                     bus.rd_addr_i, bus.rd_data_i);
  assign bus.rs2_data_o  = read_port(bus.rs2_addr_i, rs2_stored, rst_i, write_hit,
                                     bus.rd_addr_i, bus.rd_data_i);
  assign bus.write_ack_o = write_ack;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
// Drives two register file instances in lockstep, one without and one with
// the write-to-read bypass, and compares their outputs against a reference
// model through an expectation queue.
// ---------------------------------------------------------------------------
module tb_reg_file;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] value;
  } item_t;

  logic clk;
  logic rst;

  int compared;
  int mismatched;

  item_t       sb[$];
  logic [31:0] model [32];
  logic        ack_model;

  reg_file_if bus0 ();
  reg_file_if bus1 ();

  reg_file #(.BYPASS_EN(1'b0)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus0.slave)
  );

  reg_file #(.BYPASS_EN(1'b1)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a broken run still ends with a report.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Selector map: 0..2 = dut0 rs1/rs2/ack, 3..5 = dut1 rs1/rs2/ack.
  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return bus0.rs1_data_o;
      1:       return bus0.rs2_data_o;
      2:       return {31'b0, bus0.write_ack_o};
      3:       return bus1.rs1_data_o;
      4:       return bus1.rs2_data_o;
      default: return {31'b0, bus1.write_ack_o};
    endcase
  endfunction

  function automatic logic [31:0] model_read(
    input logic [4:0]  a,
    input bit          byp,
    input logic        r,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] wd
  );
    if (a == 5'd0) return 32'h0;
    if (byp && !r && we && (wa != 5'd0) && (wa == a)) return wd;
    return model[a];
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
    sb.push_back('{tag, sel, v});
  endtask

  // Pops every queued expectation and compares it against the DUT output.
  task automatic checkOutput();
    item_t it;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = observe(it.sel);
      compared++;
      assert (obs === it.value) else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%h expected=%h", it.tag, obs, it.value);
      end
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs, then advance the
  // model across the rising edge.
  task automatic applyStimulus(
    input logic        r,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input logic [4:0]  a1,
    input logic [4:0]  a2
  );
    rst = r;
    bus0.rd_we_i = we;  bus0.rd_addr_i = wa;  bus0.rd_data_i = wd;
    bus0.rs1_addr_i = a1;  bus0.rs2_addr_i = a2;
    bus1.rd_we_i = we;  bus1.rd_addr_i = wa;  bus1.rd_data_i = wd;
    bus1.rs1_addr_i = a1;  bus1.rs2_addr_i = a2;
    @(negedge clk);
    expect_val("model_rs1_nobyp", 0, model_read(a1, 1'b0, r, we, wa, wd));
    expect_val("model_rs2_nobyp", 1, model_read(a2, 1'b0, r, we, wa, wd));
    expect_val("model_ack_nobyp", 2, {31'b0, ack_model});
    expect_val("model_rs1_byp",   3, model_read(a1, 1'b1, r, we, wa, wd));
    expect_val("model_rs2_byp",   4, model_read(a2, 1'b1, r, we, wa, wd));
    expect_val("model_ack_byp",   5, {31'b0, ack_model});
    checkOutput();
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      ack_model = 1'b0;
    end else begin
      if (we && (wa != 5'd0)) model[wa] = wd;
      ack_model = we && (wa != 5'd0);
    end
    #1;
  endtask

  initial begin
    logic        r;
    logic        we;
    logic [4:0]  wa;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] wd;

    compared   = 0;
    mismatched = 0;
    ack_model  = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Initial reset: storage is undefined until the first reset edge.
    rst = 1'b1;
    bus0.rd_we_i = 1'b0; bus0.rd_addr_i = '0; bus0.rd_data_i = '0;
    bus0.rs1_addr_i = '0; bus0.rs2_addr_i = '0;
    bus1.rd_we_i = 1'b0; bus1.rd_addr_i = '0; bus1.rd_data_i = '0;
    bus1.rs1_addr_i = '0; bus1.rs2_addr_i = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    expect_val("reset_ack0", 2, 32'h0);
    expect_val("reset_ack1", 5, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd31);

    // Reset clears a previously written register.
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    expect_val("x5_written",  0, 32'hDEADBEEF);
    expect_val("x5_ack",      2, 32'h1);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    expect_val("x5_cleared0", 0, 32'h0);
    expect_val("x5_cleared1", 3, 32'h0);
    expect_val("rst_ack0",    2, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);

    // Basic write/read: operands that sum to zero in the ALU.
    applyStimulus(1'b0, 1'b1, 5'd1, 32'h00000007, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd2, 32'hFFFFFFF9, 5'd0, 5'd0);
    expect_val("x1_rd0", 0, 32'h00000007);
    expect_val("x2_rd0", 1, 32'hFFFFFFF9);
    expect_val("x1_rd1", 3, 32'h00000007);
    expect_val("x2_rd1", 4, 32'hFFFFFFF9);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);

    // x0 is hardwired: the write is dropped and raises no ack.
    applyStimulus(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    expect_val("x0_rs1",  0, 32'h0);
    expect_val("x0_rs2",  1, 32'h0);
    expect_val("x0_ack0", 2, 32'h0);
    expect_val("x0_ack1", 5, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Read during write: old value without bypass, new value with bypass.
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hAAAA0000, 5'd0, 5'd0);
    expect_val("rdw_old_nobyp", 0, 32'hAAAA0000);
    expect_val("rdw_new_byp",   3, 32'h0000BBBB);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h0000BBBB, 5'd3, 5'd3);
    expect_val("rdw_after_nobyp", 0, 32'h0000BBBB);
    expect_val("rdw_after_byp",   3, 32'h0000BBBB);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);

    // Bypass suppressed while reset is high; the write is dropped.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    expect_val("rst_byp_suppressed", 3, 32'h0);
    applyStimulus(1'b1, 1'b1, 5'd3, 32'hCCCCCCCC, 5'd3, 5'd0);
    expect_val("rst_no_write0", 0, 32'h0);
    expect_val("rst_no_write1", 3, 32'h0);
    expect_val("rst_no_ack",    5, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);

    // Random sweep with occasional aliased indices and rare resets.
    for (int n = 0; n < 1000; n++) begin
      r  = ($urandom_range(0, 99) == 0);
      we = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        a1 = wa;
        a2 = wa;
      end else begin
        a1 = 5'($urandom_range(0, 31));
        a2 = 5'($urandom_range(0, 31));
      end
      applyStimulus(r, we, wa, wd, a1, a2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_reg_file
